// File: rtl/sc_mult_scheduler_if.sv
// Request/response bundle for sc_mult_scheduler: two job requesters, one result channel, busy flag.
// Handshake: a transfer occurs on a rising clk edge where valid and ready are both high; valid must
// not depend on ready, and payload is only meaningful while valid is high.
interface sc_mult_scheduler_if #(
    parameter int LEN_LOG2 = 4
) ();
    logic                req_valid_a;
    logic                req_ready_a;
    logic [3:0]          req_x_a;
    logic [3:0]          req_y_a;
    logic                req_valid_b;
    logic                req_ready_b;
    logic [3:0]          req_x_b;
    logic [3:0]          req_y_b;
    logic                resp_valid;
    logic                resp_ready;
    logic [LEN_LOG2:0]   resp_data;
    logic                resp_id;
    logic                busy;

    modport master (
        output req_valid_a, req_x_a, req_y_a,
        output req_valid_b, req_x_b, req_y_b,
        output resp_ready,
        input  req_ready_a, req_ready_b,
        input  resp_valid, resp_data, resp_id, busy
    );

    modport slave (
        input  req_valid_a, req_x_a, req_y_a,
        input  req_valid_b, req_x_b, req_y_b,
        input  resp_ready,
        output req_ready_a, req_ready_b,
        output resp_valid, resp_data, resp_id, busy
    );
endinterface

// File: rtl/sc_mult_scheduler.sv
// Round-robin job scheduler owning a bipolar stochastic multiplier lane (two LFSRs, comparators, XNOR, ones counter).
// Define SC_SEED_RELOAD_EN to reseed both LFSRs on every job accept, making results depend only on the operands.
module sc_mult_scheduler #(
    parameter int LEN_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sc_mult_scheduler_if.slave      bus,
    output logic [1:0]              dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [30:0]         SEED1    = 31'd1;
    localparam logic [30:0]         SEED2    = 31'd2;
    localparam logic [LEN_LOG2-1:0] CYC_LAST = '1;
    localparam logic [LEN_LOG2-1:0] CYC_ONE  = {{(LEN_LOG2-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [30:0]         lfsr1_q, lfsr1_d;
    logic [30:0]         lfsr2_q, lfsr2_d;
    logic [LEN_LOG2:0]   count_q, count_d;
    logic [LEN_LOG2-1:0] cyc_q, cyc_d;
    logic [3:0]          x_q, x_d;
    logic [3:0]          y_q, y_d;
    logic                id_q, id_d;
    logic                last_q, last_d;
    logic                valid_q, valid_d;

    logic                grant_a, grant_b, accept;
    logic                sn1, sn2, prod;

    // last_q = 1 means B was served last, so A wins the next tie.
    assign grant_a = bus.req_valid_a && (!bus.req_valid_b || last_q);
    assign grant_b = bus.req_valid_b && (!bus.req_valid_a || !last_q);

    assign bus.req_ready_a = (state_q == S_IDLE) && grant_a;
    assign bus.req_ready_b = (state_q == S_IDLE) && grant_b;
    assign accept          = (bus.req_valid_a && bus.req_ready_a) ||
                             (bus.req_valid_b && bus.req_ready_b);

    assign sn1  = (lfsr1_q[3:0] < x_q);
    assign sn2  = (lfsr2_q[3:0] < y_q);
    assign prod = ~(sn1 ^ sn2);

    assign bus.resp_valid = valid_q;
    assign bus.resp_data  = count_q;
    assign bus.resp_id    = id_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign dbg_state_o    = state_q;

    always_comb begin
        state_d = state_q;
        lfsr1_d = {lfsr1_q[29:0], lfsr1_q[30] ^ lfsr1_q[27]};
        lfsr2_d = {lfsr2_q[29:0], lfsr2_q[30] ^ lfsr2_q[27]};
        count_d = count_q;
        cyc_d   = cyc_q;
        x_d     = x_q;
        y_d     = y_q;
        id_d    = id_q;
        last_d  = last_q;
        valid_d = valid_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    x_d     = grant_b ? bus.req_x_b : bus.req_x_a;
                    y_d     = grant_b ? bus.req_y_b : bus.req_y_a;
                    id_d    = grant_b;
                    last_d  = grant_b;
                    count_d = '0;
                    cyc_d   = '0;
                    state_d = S_RUN;
`ifdef SC_SEED_RELOAD_EN
                    lfsr1_d = SEED1;
                    lfsr2_d = SEED2;
`endif
                end
            end
            S_RUN: begin
                count_d = count_q + {{LEN_LOG2{1'b0}}, prod};
                cyc_d   = cyc_q + CYC_ONE;
                if (cyc_q == CYC_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // First DONE cycle raises valid; result stays held until the consumer takes it.
                valid_d = 1'b1;
                if (valid_q && bus.resp_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            lfsr1_q <= SEED1;
            lfsr2_q <= SEED2;
            count_q <= '0;
            cyc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr1_q <= lfsr1_d;
            lfsr2_q <= lfsr2_d;
            count_q <= count_d;
            cyc_q   <= cyc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            id_q    <= id_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_sc_mult_scheduler.sv
// Self-checking bench for sc_mult_scheduler: directed steps with random operands, checked against a
// stream-level reference model and a round-robin grant model.
module tb_sc_mult_scheduler;
    localparam int LEN_LOG2 = 4;
    localparam int N        = 1 << LEN_LOG2;
    localparam int W        = LEN_LOG2 + 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] dbg_state;

    sc_mult_scheduler_if #(.LEN_LOG2(LEN_LOG2)) bus ();

    sc_mult_scheduler #(.LEN_LOG2(LEN_LOG2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [W-1:0]  exp_q[$];
    int            grant_ids[$];
    int            grant_cycs[$];
    int            acc_cnt  = 0;
    int            acc_cyc  = 0;
    int            resp_cnt = 0;
    int            cyc      = 0;

    logic [30:0]   m_l1, m_l2, m_n1, m_n2;
    logic          m_last, m_acc_a, m_acc_b, m_exp_id;
    logic [3:0]    m_x, m_y;
    logic [W-1:0]  m_e;

    function automatic logic [30:0] lfsr_step(input logic [30:0] v);
        return {v[29:0], v[30] ^ v[27]};
    endfunction

    // Ones in the N-cycle XNOR product stream, starting from the given LFSR pair.
    function automatic logic [LEN_LOG2:0] model_job(input logic [30:0] a, input logic [30:0] b,
                                                    input logic [3:0] x, input logic [3:0] y);
        int ones = 0;
        for (int i = 0; i < N; i++) begin
            if ((a[3:0] < x) == (b[3:0] < y)) ones++;
            a = lfsr_step(a);
            b = lfsr_step(b);
        end
        return ones[LEN_LOG2:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: free-running LFSR pair, grant rule, expected-result queue.
    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            m_l1   = 31'd1;
            m_l2   = 31'd2;
            m_last = 1'b1;
            exp_q.delete();
        end else begin
            cyc++;
            m_n1    = lfsr_step(m_l1);
            m_n2    = lfsr_step(m_l2);
            m_acc_a = bus.req_valid_a && bus.req_ready_a;
            m_acc_b = bus.req_valid_b && bus.req_ready_b;
            if (m_acc_a || m_acc_b) begin
                check("double_grant", 32'(m_acc_a && m_acc_b), 32'd0);
                m_exp_id = (bus.req_valid_a && bus.req_valid_b) ? ~m_last : bus.req_valid_b;
                check("grant_id", 32'(m_acc_b), 32'(m_exp_id));
                m_x = m_acc_b ? bus.req_x_b : bus.req_x_a;
                m_y = m_acc_b ? bus.req_y_b : bus.req_y_a;
`ifdef SC_SEED_RELOAD_EN
                m_n1 = 31'd1;
                m_n2 = 31'd2;
`endif
                exp_q.push_back({m_acc_b, model_job(m_n1, m_n2, m_x, m_y)});
                m_last = m_acc_b;
                acc_cnt++;
                acc_cyc = cyc;
                grant_ids.push_back(int'(m_acc_b));
                grant_cycs.push_back(cyc);
            end
            if (bus.resp_valid && bus.resp_ready) begin
                resp_cnt++;
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    check("resp_id_data", 32'({bus.resp_id, bus.resp_data}), 32'(m_e));
                end
            end
            m_l1 = m_n1;
            m_l2 = m_n2;
        end
    end

    task automatic wait_accept(input int target);
        int k = 0;
        while (acc_cnt < target && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (acc_cnt < target) check("accept_timeout", 32'(acc_cnt), 32'(target));
    endtask

    task automatic wait_resp(input string tag);
        int k = 0;
        while (!bus.resp_valid && k < 4 * N) begin
            @(negedge clk);
            k++;
        end
        if (!bus.resp_valid) check(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (bus.busy && k < 8 * N) begin
            @(negedge clk);
            k++;
        end
        if (bus.busy) check(tag, 32'd1, 32'd0);
    endtask

    task automatic run_job(input logic use_b, input logic [3:0] x, input logic [3:0] y,
                           output logic [LEN_LOG2:0] data);
        if (use_b) begin
            bus.req_x_b = x; bus.req_y_b = y; bus.req_valid_b = 1'b1;
        end else begin
            bus.req_x_a = x; bus.req_y_a = y; bus.req_valid_a = 1'b1;
        end
        wait_accept(acc_cnt + 1);
        bus.req_valid_a = 1'b0;
        bus.req_valid_b = 1'b0;
        wait_resp("run_job_resp_timeout");
        data = bus.resp_data;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int                  lat, seen, rdy, g, k;
        logic                exp_first;
        logic [W-1:0]        held;
        logic [LEN_LOG2:0]   d1, d2;

        bus.req_valid_a = 1'b0; bus.req_x_a = '0; bus.req_y_a = '0;
        bus.req_valid_b = 1'b0; bus.req_x_b = '0; bus.req_y_b = '0;
        bus.resp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_data",  32'(bus.resp_data),  32'd0);
        check("rst_resp_id",    32'(bus.resp_id),    32'd0);
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_state",      32'(dbg_state),      32'd0);
        bus.req_valid_a = 1'b1;
        bus.req_valid_b = 1'b1;
        #1;
        check("tie_ready_a", 32'(bus.req_ready_a), 32'd1);
        check("tie_ready_b", 32'(bus.req_ready_b), 32'd0);
        bus.req_valid_b = 1'b0;

        // A: x=0, y=0 gives an all-ones product stream, latency N+1.
        bus.req_x_a = 4'd0; bus.req_y_a = 4'd0;
        wait_accept(1);
        bus.req_valid_a = 1'b0;
        check("run_busy",    32'(bus.busy),        32'd1);
        check("run_ready_a", 32'(bus.req_ready_a), 32'd0);
        wait_resp("zero_job_timeout");
        lat = cyc - acc_cyc;
        check("zero_job_latency", 32'(lat), 32'(N + 1));
        check("zero_job_data", 32'(bus.resp_data), 32'(N));
        check("zero_job_id",   32'(bus.resp_id),   32'd0);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("zero_job_handshake", 32'(bus.resp_valid), 32'd0);

        // B: x=15, y=3, submitted twice.
        run_job(1'b1, 4'd15, 4'd3, d1);
        run_job(1'b1, 4'd15, 4'd3, d2);
`ifdef SC_SEED_RELOAD_EN
        check("seeded_model", 32'(d1), 32'(model_job(31'd1, 31'd2, 4'd15, 4'd3)));
        check("seeded_repeat", 32'(d2), 32'(d1));
`endif

        // Backpressure in DONE with B waiting.
        bus.req_x_a = 4'($urandom_range(0, 15)); bus.req_y_a = 4'($urandom_range(0, 15));
        bus.req_valid_a = 1'b1;
        wait_accept(acc_cnt + 1);
        bus.req_valid_a = 1'b0;
        bus.req_x_b = 4'($urandom_range(0, 15)); bus.req_y_b = 4'($urandom_range(0, 15));
        bus.req_valid_b = 1'b1;
        wait_resp("bp_resp_timeout");
        held = {bus.resp_id, bus.resp_data};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid",   32'(bus.resp_valid),                32'd1);
            check("bp_payload", 32'({bus.resp_id, bus.resp_data}), 32'(held));
            check("bp_ready_a", 32'(bus.req_ready_a),               32'd0);
            check("bp_ready_b", 32'(bus.req_ready_b),               32'd0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_complete", 32'(bus.resp_valid), 32'd0);
        wait_accept(acc_cnt + 1);
        bus.req_valid_b = 1'b0;
        wait_idle("bp_drain_timeout");

        // Both requesters continuously valid: alternating grants, N+3 apart.
        g = grant_ids.size();
        exp_first = ~m_last;
        bus.req_x_a = 4'($urandom_range(0, 15)); bus.req_y_a = 4'($urandom_range(0, 15));
        bus.req_x_b = 4'($urandom_range(0, 15)); bus.req_y_b = 4'($urandom_range(0, 15));
        bus.req_valid_a = 1'b1;
        bus.req_valid_b = 1'b1;
        rdy = 0;
        k = 0;
        while (acc_cnt < acc_cnt - (grant_ids.size() - g) + 4 && k < 200) begin
            #1;
            if (bus.req_ready_a || bus.req_ready_b) rdy++;
            @(negedge clk);
            k++;
        end
        bus.req_valid_a = 1'b0;
        bus.req_valid_b = 1'b0;
        if (grant_ids.size() < g + 4) begin
            check("alt_timeout", 32'(grant_ids.size() - g), 32'd4);
        end else begin
            check("alt_ready_pulses", 32'(rdy), 32'd4);
            for (int i = 0; i < 4; i++) begin
                check("alt_order", 32'(grant_ids[g + i]), 32'(exp_first ^ logic'(i & 1)));
                if (i > 0) check("alt_spacing", 32'(grant_cycs[g + i] - grant_cycs[g + i - 1]), 32'(N + 3));
            end
        end
        wait_idle("alt_drain_timeout");
        bus.resp_ready = 1'b0;

        // Reset five cycles into RUN discards the job.
        bus.req_x_a = 4'($urandom_range(0, 15)); bus.req_y_a = 4'($urandom_range(0, 15));
        bus.req_valid_a = 1'b1;
        wait_accept(acc_cnt + 1);
        bus.req_valid_a = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("mid_rst_busy",       32'(bus.busy),       32'd0);
        check("mid_rst_resp_data",  32'(bus.resp_data),  32'd0);
        check("mid_rst_resp_id",    32'(bus.resp_id),    32'd0);
        check("mid_rst_state",      32'(dbg_state),      32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        seen = 0;
        for (int i = 0; i < N + 5; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        check("mid_rst_no_resp", 32'(seen), 32'd0);
        bus.req_x_a = 4'($urandom_range(0, 15)); bus.req_y_a = 4'($urandom_range(0, 15));
        bus.req_x_b = 4'($urandom_range(0, 15)); bus.req_y_b = 4'($urandom_range(0, 15));
        bus.req_valid_a = 1'b1;
        bus.req_valid_b = 1'b1;
        #1;
        check("post_rst_tie_a", 32'(bus.req_ready_a), 32'd1);
        check("post_rst_tie_b", 32'(bus.req_ready_b), 32'd0);
        bus.resp_ready = 1'b1;
        wait_accept(acc_cnt + 1);
        bus.req_valid_a = 1'b0;
        wait_accept(acc_cnt + 1);
        bus.req_valid_b = 1'b0;
        wait_idle("post_rst_drain_timeout");
        bus.resp_ready = 1'b0;

        // Random traffic with random response backpressure.
        for (int j = 0; j < 8; j++) begin
            bus.req_x_a = 4'($urandom_range(0, 15)); bus.req_y_a = 4'($urandom_range(0, 15));
            bus.req_x_b = 4'($urandom_range(0, 15)); bus.req_y_b = 4'($urandom_range(0, 15));
            bus.req_valid_a = 1'($urandom_range(0, 1));
            bus.req_valid_b = ~bus.req_valid_a | 1'($urandom_range(0, 1));
            wait_accept(acc_cnt + 1);
            bus.req_valid_a = 1'b0;
            bus.req_valid_b = 1'b0;
            k = 0;
            while (bus.busy && k < 8 * N) begin
                bus.resp_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                k++;
            end
            bus.resp_ready = 1'b0;
            if (bus.busy) check("rand_timeout", 32'd1, 32'd0);
        end

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("resp_count", 32'(resp_cnt), 32'(acc_cnt - 1));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sc_mult_scheduler.md
# sc_mult_scheduler

Job scheduler for a shared bipolar stochastic multiplier lane. Two requesters each submit a pair of 4-bit probabilities. A round-robin arbiter grants the lane to one requester at a time. The block runs the stochastic stream for a fixed number of cycles, counts the ones, and returns the count with a requester ID over a valid/ready response channel. It sits between the host-facing register logic and the LFSR/comparator/XNOR datapath, and owns that datapath.

## Interface
- `LEN_LOG2`, default 4: stream length N = 2^LEN_LOG2 cycles; legal range 3..8.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-high (despite the name); one clock `clk`.
- `req_valid_a`  in  1  requester A has a job.
- `req_ready_a`  out  1  job A accepted when `req_valid_a` and `req_ready_a` are both high.
- `req_x_a`, `req_y_a`  in  4 each  requester A operand probabilities, value/16.
- `req_valid_b`, `req_ready_b`, `req_x_b`, `req_y_b`: same as A, for requester B.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes result.
- `resp_data`  out  LEN_LOG2+1  count of ones in the product stream, 0..N.
- `resp_id`  out  1  0 = job came from A, 1 = job came from B.
- `busy`  out  1  high in RUN and DONE.

## Operation
- Two 31-bit LFSRs, polynomial x^31+x^28+1.
  - Shift left each cycle; bit0 gets bit27 ^ bit30.
  - Seeds: LFSR1 = 1, LFSR2 = 2.
- Per RUN cycle:
  - sn1 = (lfsr1[3:0] < x)
  - sn2 = (lfsr2[3:0] < y)
  - prod = ~(sn1 ^ sn2)
  - count += prod
- Unsigned compare. Comparator, XNOR and counter update are in the same cycle, with no extra pipeline stage.
- Count is LEN_LOG2+1 bits, so it never wraps. The all-ones stream gives exactly N.
- States:
  - IDLE: ready asserted combinationally to the arbiter winner only.
    - On handshake, latch x, y and id, clear count and the cycle counter, go to RUN.
  - RUN: for exactly N cycles, then go to DONE.
  - DONE: `resp_valid` = 1. Data and ID are held stable until `resp_ready` = 1, then go to IDLE.
- Arbiter (IDLE only):
  - Only one valid: that requester wins.
  - Both valid: the requester not served last wins. The last-served pointer resets to B, so A wins first.
  - The pointer updates only on an accepted handshake.
- Both ready outputs are 0 outside IDLE. Valid requests are held off without loss, and requester operands are not sampled then.
- Bipolar interpretation, for the host: product ≈ 2·count/N − 1.

## Timing
- Reset values:
  - `req_ready_a`/`req_ready_b`: follow the arbiter rule in IDLE (A wins a tie first).
  - `resp_valid`, `resp_data`, `resp_id`, `busy`: 0.
  - State: IDLE; pointer: B.
  - LFSRs = seeds; count = 0.
- Accept at edge k:
  - RUN occupies cycles k+1..k+N.
  - `resp_valid` rises after edge k+N+1.
  - Response handshake at edge m returns to IDLE; the next accept is possible at edge m+1.
- Minimum job period: N+3 cycles with `resp_ready` tied high.
- `resp_ready` high while not in DONE: ignored.
- Reset asserted mid-RUN or mid-DONE: the job is discarded, no response is produced, and all state returns to the reset values immediately.
- LFSRs free-run every cycle in all states, unless reseeding is enabled (see Configuration).

## Configuration
- `SC_SEED_RELOAD_EN` defined:
  - On the accept edge the LFSRs load their seeds, so the first RUN cycle sees lfsr1 = 1 and lfsr2 = 2.
  - Results depend only on (x, y, LEN_LOG2): deterministic and repeatable.
- Undefined:
  - The LFSRs never reload after reset.
  - Results depend on the arrival time of each job; consecutive identical jobs may differ.

## Test plan
- Macro on, N = 16:
  - A submits x = 0, y = 0. Expect sn1 = sn2 = 0 every cycle, so `resp_data` = 16 and `resp_id` = 0.
  - `resp_valid` rises exactly 17 cycles after the accept edge.
- Macro on:
  - B submits x = 15, y = 3. Expect `resp_data` equal to the bit-accurate model seeded 1/2 and `resp_id` = 1.
  - Resubmit the same job. Expect an identical result.
- Both valid continuously with `resp_ready` = 1:
  - Grants alternate A, B, A, B.
  - Each ready pulse lasts 1 cycle, and accepts are spaced N+3 cycles apart.
- Backpressure: hold `resp_ready` = 0 for 10 cycles in DONE.
  - `resp_valid`, `resp_data` and `resp_id` stay stable.
  - Both ready outputs stay 0.
  - The response completes one cycle after `resp_ready` rises.
- Reset: assert `rst_n` high 5 cycles into RUN.
  - All outputs go to their reset values; no response appears.
  - A job submitted after reset completes normally, with A winning a tie.
- Macro off: submit the same job twice back to back.
  - Each `resp_data` equals the model run from the free-running LFSR state at its accept edge.
